// File: rtl/prog_writer_pkg.sv
// rtl/prog_writer_pkg.sv - shared types and constants for the program writer
package prog_writer_pkg;

  localparam int ADDR_W = 10;
  localparam logic [8:0] HALT_WORD = 9'h1FF;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  typedef enum logic [4:0] {
    OP_LSL  = 5'd0,  OP_LSR = 5'd1,  OP_ORR = 5'd2,  OP_XOR = 5'd3,
    OP_RXR  = 5'd4,  OP_ADD = 5'd5,  OP_SUB = 5'd6,  OP_MOV = 5'd7,
    OP_JE   = 5'd8,  OP_JNE = 5'd9,  OP_SPC = 5'd10, OP_LUT = 5'd11,
    OP_LDR  = 5'd12, OP_STR = 5'd13, OP_CPY = 5'd14, OP_CTC = 5'd15,
    OP_CTI  = 5'd16, OP_CTS = 5'd17, OP_CBF = 5'd18, OP_SBS = 5'd19,
    OP_DBS  = 5'd20, OP_HALT = 5'd21
  } op_kind_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

endpackage

// File: rtl/prog_writer_if.sv
// rtl/prog_writer_if.sv - instruction handshake channel into the program writer
interface prog_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] op;
  logic [2:0] rd;
  logic [2:0] rs;
  logic [4:0] imm;
  logic [1:0] sel;
  logic       flag;

  modport master (output in_valid, op, rd, rs, imm, sel, flag, input in_ready);
  modport slave  (input in_valid, op, rd, rs, imm, sel, flag, output in_ready);
endinterface

// File: rtl/prog_writer_instr_field_enc.sv
// rtl/prog_writer_instr_field_enc.sv - combinational instruction encoder and legality check
module instr_field_enc
  import prog_writer_pkg::*;
(
  input  logic [4:0] op,
  input  logic [2:0] rd,
  input  logic [2:0] rs,
  input  logic [4:0] imm,
  input  logic [1:0] sel,
  input  logic       flag,
  output logic [8:0] word,
  output logic       illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_LSL:  word = {3'b000, rd, rs};
      OP_LSR:  word = {3'b001, rd, rs};
      OP_ORR:  begin word = {4'b1101, rd, rs[1:0]}; illegal = ~rs[2]; end
      OP_XOR:  word = {4'b0110, rd, 2'b00};
      OP_RXR:  word = {4'b0111, rd, 2'b00};
      OP_ADD:  word = {4'b1110, rd, 2'b00};
      OP_SUB:  word = {4'b1110, rd, 2'b10};
      // Imm=31 would alias the HALT word
      OP_MOV:  begin word = {4'b1111, imm}; illegal = (imm == 5'd31); end
      OP_JE:   word = {4'b1000, 1'b0, sel, 2'b00};
      OP_JNE:  word = {4'b1000, 1'b1, sel, 2'b00};
      OP_SPC:  word = {4'b1001, sel, flag, 2'b00};
      OP_LUT:  word = {4'b1010, rd, flag, 1'b0};
      OP_LDR:  word = {5'b01000, rd, 1'b0};
      OP_STR:  word = {5'b01001, rd, 1'b0};
      OP_SBS:  word = {5'b01010, rd, 1'b0};
      OP_DBS:  word = {5'b01011, rd, 1'b0};
      OP_CPY:  word = {4'b1100, rd, 2'b00};
      OP_CTC:  word = {6'b101100, sel, 1'b0};
      OP_CTI:  word = {6'b101101, sel, 1'b0};
      OP_CTS:  begin word = {6'b101110, sel, 1'b0}; illegal = (sel == 2'd3); end
      OP_CBF:  word = 9'b101111000;
      OP_HALT: word = HALT_WORD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/prog_writer.sv
// rtl/prog_writer.sv - session FSM writing encoded instructions into instruction memory
module prog_writer
  import prog_writer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_writer_if.slave      bus,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic [1:0]        err_code
);

  state_t     state, next_state;
  logic [8:0] word;
  logic       illegal;
  logic       xfer;
  logic       restart;

  instr_field_enc u_enc (
    .op      (bus.op),
    .rd      (bus.rd),
    .rs      (bus.rs),
    .imm     (bus.imm),
    .sel     (bus.sel),
    .flag    (bus.flag),
    .word    (word),
    .illegal (illegal)
  );

  assign bus.in_ready = (state == S_RUN);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign restart      = start && (state != S_RUN);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_RUN: begin
        if (xfer) begin
          if (illegal)                           next_state = S_ERR;
          else if (bus.op == OP_HALT)            next_state = S_DONE;
          else if (count == (2**ADDR_W) - 1)     next_state = S_ERR;
        end
      end
      default: if (start) next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      done     <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      wr_en <= 1'b0;
      if (restart) begin
        wr_addr  <= '0;
        count    <= '0;
        done     <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        if (xfer && illegal) begin
          err_code <= ERR_ILLEGAL;
        end else if (xfer) begin
          wr_en   <= 1'b1;
          wr_addr <= count[ADDR_W-1:0];
          wr_data <= word;
          count   <= count + 1'b1;
        end
        // The state already left RUN at the accepting edge; flags land once the write completes
        if (wr_en && state == S_DONE) done     <= 1'b1;
        if (wr_en && state == S_ERR)  err_code <= ERR_OVERFLOW;
      end
    end
  end

endmodule

// File: tb/tb_prog_writer.sv
// tb/tb_prog_writer.sv - randomized self-checking bench for prog_writer
module tb_prog_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [10:0] count;
  logic        done;
  logic [1:0]  err_code;

  prog_writer_if bus ();

  prog_writer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .count    (count),
    .done     (done),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_run, m_done, m_wr, p_done, p_ovf;
  int m_count, m_err, e_addr, e_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_word(input int o, input int rd, input int rs, input int imm,
                                  input int sel, input int flag, output bit ill);
    ill = 1'b0;
    case (o)
      0:  return 0 * 64 + rd * 8 + rs;
      1:  return 1 * 64 + rd * 8 + rs;
      2:  begin ill = (rs < 4); return 13 * 32 + rd * 4 + rs % 4; end
      3:  return 6 * 32 + rd * 4;
      4:  return 7 * 32 + rd * 4;
      5:  return 14 * 32 + rd * 4;
      6:  return 14 * 32 + rd * 4 + 2;
      7:  begin ill = (imm == 31); return 15 * 32 + imm; end
      8:  return 8 * 32 + sel * 4;
      9:  return 8 * 32 + 16 + sel * 4;
      10: return 9 * 32 + sel * 8 + flag * 4;
      11: return 10 * 32 + rd * 4 + flag * 2;
      12: return 8 * 16 + rd * 2;
      13: return 9 * 16 + rd * 2;
      14: return 12 * 32 + rd * 4;
      15: return 44 * 8 + sel * 2;
      16: return 45 * 8 + sel * 2;
      17: begin ill = (sel == 3); return 46 * 8 + sel * 2; end
      18: return 47 * 8;
      19: return 10 * 16 + rd * 2;
      20: return 11 * 16 + rd * 2;
      21: return 511;
      default: begin ill = 1'b1; return 0; end
    endcase
  endfunction

  task automatic step(input logic rst_n, input logic st, input logic vld, input logic [4:0] o,
                      input logic [2:0] rd_v, input logic [2:0] rs_v, input logic [4:0] imm_v,
                      input logic [1:0] sel_v, input logic flag_v);
    bit ill;
    int w;
    reset = rst_n; start = st; bus.in_valid = vld; bus.op = o;
    bus.rd = rd_v; bus.rs = rs_v; bus.imm = imm_v; bus.sel = sel_v; bus.flag = flag_v;
    @(negedge clk);
    check("in_ready", bus.in_ready, m_run);
    @(posedge clk);
    m_wr = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_count = 0; m_done = 0; m_err = 0; p_done = 0; p_ovf = 0;
    end else if (st && !m_run) begin
      m_run = 1; m_count = 0; m_done = 0; m_err = 0; p_done = 0; p_ovf = 0;
    end else begin
      if (p_done) m_done = 1;
      if (p_ovf)  m_err  = 2;
      p_done = 0; p_ovf = 0;
      if (vld && m_run) begin
        w = ref_word(int'(o), int'(rd_v), int'(rs_v), int'(imm_v), int'(sel_v), int'(flag_v), ill);
        if (ill) begin
          m_err = 1; m_run = 0;
        end else begin
          m_wr = 1; e_addr = m_count; e_data = w; m_count++;
          if (o == 5'd21)          begin m_run = 0; p_done = 1; end
          else if (m_count == 1024) begin m_run = 0; p_ovf = 1; end
        end
      end
    end
    #1;
    check("wr_en", wr_en, m_wr);
    if (m_wr) begin
      check("wr_addr", wr_addr, e_addr);
      check("wr_data", wr_data, e_data);
    end
    check("count", count, m_count);
    check("done", done, m_done);
    check("err_code", err_code, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_start();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic instr(input logic [4:0] o, input logic [2:0] rd_v, input logic [2:0] rs_v,
                       input logic [4:0] imm_v, input logic [1:0] sel_v, input logic flag_v);
    step(1, 0, 1, o, rd_v, rs_v, imm_v, sel_v, flag_v);
  endtask

  initial begin
    reset = 0; start = 0; bus.in_valid = 0; bus.op = 0;
    bus.rd = 0; bus.rs = 0; bus.imm = 0; bus.sel = 0; bus.flag = 0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    // valid while IDLE must be ignored
    instr(5'd0, 3, 3, 0, 0, 0);

    do_start();
    instr(5'd7, 0, 0, 5, 0, 0);
    check("mov_word", wr_data, 9'h1E5);
    instr(5'd5, 2, 0, 0, 0, 0);
    check("add_word", wr_data, 9'h1C8);
    instr(5'd21, 0, 0, 0, 0, 0);
    check("halt_word", wr_data, 9'h1FF);
    idle(2);
    check("halt_done", done, 1);
    check("halt_count", count, 3);
    instr(5'd1, 1, 1, 0, 0, 0);

    do_start();
    instr(5'd2, 1, 2, 0, 0, 0);
    idle(1);
    check("orr_err", err_code, 1);
    do_start();
    check("restart_err", err_code, 0);

    instr(5'd9, 0, 0, 0, 2, 0);
    instr(5'd10, 0, 0, 0, 1, 1);
    check("spc_word", wr_data, 9'h12C);
    instr(5'd17, 0, 0, 0, 3, 0);
    idle(1);
    check("cts_err", err_code, 1);

    for (int n = 0; n < 1500; n++) begin
      logic [4:0] o;
      o = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
      if ($urandom_range(0, 299) == 0)
        step(0, 1, 1, o, 0, 0, 0, 0, 0);
      else
        step(1, (!m_run && $urandom_range(0, 3) == 0) || ($urandom_range(0, 9) == 0),
             $urandom_range(0, 3) != 0, o, 3'($urandom), 3'($urandom), 5'($urandom),
             2'($urandom), 1'($urandom));
    end

    do_start();
    for (int i = 0; i < 3; i++) instr(5'd0, 3'(i), 3'(i), 0, 0, 0);
    step(0, 1, 1, 5'd0, 1, 1, 0, 0, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    do_start();
    instr(5'd0, 5, 5, 0, 0, 0);
    check("restart_addr", wr_addr, 0);

    do_start();
    for (int i = 0; i < 1026; i++) instr(5'd0, 3'($urandom), 3'($urandom), 0, 0, 0);
    idle(1);
    check("ovf_err", err_code, 2);
    check("ovf_count", count, 1024);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
